// File: rtl/hamming_pkg.sv
// hamming_pkg: shared mode enum and SECDED codeword layout helpers
// Layout: code[pos-1] holds Hamming position pos (1..N), parity bits sit at powers of two, code[N] is overall parity
package hamming_pkg;
  typedef enum logic [1:0] {SISO = 2'b00, SIPO = 2'b01, PISO = 2'b10, PIPO = 2'b11} mode_t;
  function automatic int par_bits(input int w);
    int p;
    p = 1;
    while ((1 << p) < w + p + 1) p = p + 1;
    return p;
  endfunction
  function automatic int cw_bits(input int w);
    return w + par_bits(w) + 1;
  endfunction
  function automatic bit is_pow2(input int pos);
    return pos != 0 && (pos & (pos - 1)) == 0;
  endfunction
  function automatic int data_pos(input int i);
    int pos, k;
    pos = 0;
    k = -1;
    while (k < i) begin
      pos = pos + 1;
      if (!is_pow2(pos)) k = k + 1;
    end
    return pos;
  endfunction
endpackage

// File: rtl/hamming_secded_codec.sv
// hamming_secded_codec: combinational SECDED encoder and decoder
// Ports: data_in -> code_out (encode); code_in -> data_out, syndrome, single_err, double_err (decode)
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           data_in,
  output logic [cw_bits(WIDTH)-1:0]  code_out,
  input  logic [cw_bits(WIDTH)-1:0]  code_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [par_bits(WIDTH)-1:0] syndrome,
  output logic                       single_err,
  output logic                       double_err
);
  localparam int P = par_bits(WIDTH);
  localparam int N = WIDTH + P;
  logic overall_odd;
  always_comb begin
    code_out = '0;
    for (int i = 0; i < WIDTH; i++) code_out[data_pos(i)-1] = data_in[i];
    for (int k = 0; k < P; k++)
      for (int pos = 1; pos <= N; pos++)
        if (pos[k] && !is_pow2(pos)) code_out[(1 << k)-1] = code_out[(1 << k)-1] ^ code_out[pos-1];
    code_out[N] = ^code_out[N-1:0];
  end
  assign overall_odd = ^code_in;
  // odd overall parity means one flipped bit; syndrome 0 then points at the overall bit itself
  assign single_err = overall_odd;
  assign double_err = !overall_odd && syndrome != '0;
  always_comb begin
    syndrome = '0;
    for (int k = 0; k < P; k++)
      for (int pos = 1; pos <= N; pos++)
        if (pos[k]) syndrome[k] = syndrome[k] ^ code_in[pos-1];
    data_out = '0;
    for (int i = 0; i < WIDTH; i++)
      data_out[i] = code_in[data_pos(i)-1] ^ (single_err && int'(syndrome) == data_pos(i));
  end
endmodule

// File: rtl/hamming_univ_reg.sv
// hamming_univ_reg: universal shift register stored as a self-scrubbing SECDED codeword
// Ports: enable/mode/load/serial_in/parallel_in drive the next data; err_clr clears err_uncorr;
// serial_out/parallel_out show corrected data; err_corr, err_uncorr, corr_count report errors
module hamming_univ_reg
  import hamming_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             err_clr,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [CNT_W-1:0] corr_count
);
  localparam int P = par_bits(WIDTH);
  localparam int CW = cw_bits(WIDTH);
  logic [CW-1:0] code, code_next;
  logic [WIDTH-1:0] d, nd;
  logic [P-1:0] syn;
  logic single, dbl, do_load, write;
  mode_t m;
  hamming_secded_codec #(.WIDTH(WIDTH)) codec (
    .data_in(nd), .code_out(code_next), .code_in(code),
    .data_out(d), .syndrome(syn), .single_err(single), .double_err(dbl)
  );
  assign m = mode_t'(mode);
  assign do_load = enable && load && (m == PISO || m == PIPO);
  always_comb begin
    nd = !enable ? d :
         do_load ? parallel_in :
         m == PIPO ? d :
         m == PISO ? {d[WIDTH-2:0], 1'b0} : {d[WIDTH-2:0], serial_in};
  end
  // an uncorrectable word is frozen so the evidence survives; only a fresh load may replace it
  assign write = syn == '0 || single || do_load;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= '0;
      err_uncorr <= 1'b0;
      corr_count <= '0;
    end else begin
      if (write) code <= code_next;
      if (dbl) err_uncorr <= 1'b1;
      else if (err_clr) err_uncorr <= 1'b0;
      if (single && corr_count != '1) corr_count <= corr_count + CNT_W'(1);
    end
  end
  assign parallel_out = d;
  assign serial_out = d[WIDTH-1];
  assign err_corr = single;
endmodule

// File: tb/tb_hamming_univ_reg.sv
// tb_hamming_univ_reg: directed scoreboard bench for hamming_univ_reg (WIDTH=8, CNT_W=8 and 2)
module tb_hamming_univ_reg;
  logic clk = 0, rst = 1, enable = 0, load = 0, serial_in = 0, err_clr = 0;
  logic [1:0] mode = 2'b00;
  logic [7:0] parallel_in = 8'h00;
  logic serial_out, err_corr, err_uncorr, so2, ec2, eu2;
  logic [7:0] parallel_out, po2, corr_count;
  logic [1:0] cnt2;
  logic [12:0] inj_a, inj_b;
  typedef struct packed {
    logic [7:0] pd;
    logic so, ec, eu;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;
  exp_t q[$];
  string qn[$];
  exp_t e;
  string nm_cur;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  hamming_univ_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load), .serial_in(serial_in),
    .parallel_in(parallel_in), .err_clr(err_clr), .serial_out(serial_out), .parallel_out(parallel_out),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .corr_count(corr_count)
  );
  hamming_univ_reg #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load), .serial_in(serial_in),
    .parallel_in(parallel_in), .err_clr(err_clr), .serial_out(so2), .parallel_out(po2),
    .err_corr(ec2), .err_uncorr(eu2), .corr_count(cnt2)
  );
  task automatic tick(input logic en_i, input logic [1:0] md, input logic ld, input logic si,
                      input logic [7:0] pin, input logic clr);
    enable = en_i;
    mode = md;
    load = ld;
    serial_in = si;
    parallel_in = pin;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask
  task automatic inject(input logic [12:0] mask);
    #1;
    inj_a = dut.code ^ mask;
    inj_b = dut2.code ^ mask;
    force dut.code = inj_a;
    force dut2.code = inj_b;
    #1;
    release dut.code;
    release dut2.code;
  endtask
  task automatic chk(input string nm, input logic [7:0] pd, input logic ec, input logic eu, input logic [7:0] cnt);
    exp_t x;
    x.pd = pd;
    x.so = pd[7];
    x.ec = ec;
    x.eu = eu;
    x.cnt = cnt;
    x.cnt2 = cnt > 8'd3 ? 2'd3 : cnt[1:0];
    q.push_back(x);
    qn.push_back(nm);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      nm_cur = qn.pop_front();
      total++;
      if ({parallel_out, serial_out, err_corr, err_uncorr, corr_count, cnt2} !== e) begin
        bad++;
        $display("FAIL %s: got po=%h so=%b ec=%b eu=%b cnt=%0d cnt2=%0d, expected po=%h so=%b ec=%b eu=%b cnt=%0d cnt2=%0d",
                 nm_cur, parallel_out, serial_out, err_corr, err_uncorr, corr_count, cnt2,
                 e.pd, e.so, e.ec, e.eu, e.cnt, e.cnt2);
      end
    end
  end
  initial begin
    #20000;
    bad++;
    $display("FAIL timeout: simulation did not finish in time, total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    @(posedge clk);
    #1;
    total++;
    if ({parallel_out, serial_out, err_corr, err_uncorr, corr_count, po2, so2, ec2, eu2, cnt2} !== '0) begin
      bad++;
      $display("FAIL reset_direct: po=%h so=%b ec=%b eu=%b cnt=%0d po2=%h so2=%b ec2=%b eu2=%b cnt2=%0d",
               parallel_out, serial_out, err_corr, err_uncorr, corr_count, po2, so2, ec2, eu2, cnt2);
    end
    chk("reset", 8'h00, 0, 0, 0);
    rst = 0;
    tick(1, 2'b01, 0, 1, 8'h00, 0); chk("sipo1", 8'h01, 0, 0, 0);
    tick(1, 2'b01, 0, 0, 8'h00, 0); chk("sipo2", 8'h02, 0, 0, 0);
    tick(1, 2'b01, 0, 1, 8'h00, 0); chk("sipo3", 8'h05, 0, 0, 0);
    tick(1, 2'b01, 0, 1, 8'h00, 0); chk("sipo4", 8'h0B, 0, 0, 0);
    tick(1, 2'b11, 1, 0, 8'hDB, 0); chk("pipo_load", 8'hDB, 0, 0, 0);
    tick(0, 2'b11, 0, 0, 8'h00, 0); inject(13'h0800); chk("flip_d7", 8'hDB, 1, 0, 0);
    tick(0, 2'b11, 1, 0, 8'h55, 0); chk("scrub_d7", 8'hDB, 0, 0, 1);
    tick(0, 2'b11, 0, 0, 8'h00, 0); inject(13'h0080); chk("flip_p3", 8'hDB, 1, 0, 1);
    tick(0, 2'b11, 0, 0, 8'h00, 0); chk("scrub_p3", 8'hDB, 0, 0, 2);
    tick(0, 2'b11, 0, 0, 8'h00, 0); inject(13'h1000); chk("flip_ovr", 8'hDB, 1, 0, 2);
    tick(0, 2'b11, 0, 0, 8'h00, 0); chk("scrub_ovr", 8'hDB, 0, 0, 3);
    tick(0, 2'b11, 0, 0, 8'h00, 0); inject(13'h0001); chk("flip_p0", 8'hDB, 1, 0, 3);
    tick(0, 2'b11, 0, 0, 8'h00, 0); chk("scrub_p0", 8'hDB, 0, 0, 4);
    tick(0, 2'b11, 0, 0, 8'h00, 0); inject(13'h0004); chk("flip_d0", 8'hDB, 1, 0, 4);
    tick(1, 2'b01, 0, 0, 8'h00, 0); chk("shift_corr", 8'hB6, 0, 0, 5);
    tick(1, 2'b11, 1, 0, 8'hDB, 0); chk("reload", 8'hDB, 0, 0, 5);
    tick(0, 2'b11, 0, 0, 8'h00, 0); inject(13'h0300); chk("dbl_inject", 8'hEB, 0, 0, 5);
    tick(1, 2'b01, 0, 1, 8'h00, 0); chk("dbl_shift", 8'hEB, 0, 1, 5);
    tick(1, 2'b01, 0, 1, 8'h00, 1); chk("dbl_set_wins", 8'hEB, 0, 1, 5);
    tick(1, 2'b11, 1, 0, 8'hEF, 0); chk("dbl_load", 8'hEF, 0, 1, 5);
    tick(0, 2'b11, 0, 0, 8'h00, 0); chk("sticky", 8'hEF, 0, 1, 5);
    tick(0, 2'b11, 0, 0, 8'h00, 1); chk("err_clr", 8'hEF, 0, 0, 5);
    tick(1, 2'b10, 1, 0, 8'hB1, 0); chk("piso_load", 8'hB1, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso1", 8'h62, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso2", 8'hC4, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso3", 8'h88, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso4", 8'h10, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso5", 8'h20, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso6", 8'h40, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso7", 8'h80, 0, 0, 5);
    tick(1, 2'b10, 0, 1, 8'h00, 0); chk("piso8", 8'h00, 0, 0, 5);
    tick(1, 2'b00, 0, 1, 8'h00, 0); chk("siso1", 8'h01, 0, 0, 5);
    tick(1, 2'b00, 0, 1, 8'h00, 0); chk("siso2", 8'h03, 0, 0, 5);
    tick(1, 2'b00, 0, 1, 8'h00, 0); chk("siso3", 8'h07, 0, 0, 5);
    tick(1, 2'b00, 0, 1, 8'h00, 0);
    #1;
    rst = 1;
    chk("rst_async", 8'h00, 0, 0, 0);
    tick(1, 2'b00, 0, 1, 8'h00, 0); chk("rst_hold", 8'h00, 0, 0, 0);
    rst = 0;
    tick(1, 2'b00, 0, 1, 8'h00, 0); chk("post_rst", 8'h01, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
